keypoint_tile_scheduler: RTL and testbench

KEYPOINT_TILE_SCHEDULER -- requirements
Module: keypoint_tile_scheduler

---
 rtl/keypoint_tile_scheduler.sv | 164 ++++++++++++++++
 tb/tb_keypoint_tile_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_tile_scheduler.sv
// Walks a frame tile by tile, keeps the strongest corner of each tile and offers it to a matcher.
// Optional watchdog on the matcher response is built in when KTS_TIMEOUT_EN is defined.
module keypoint_tile_scheduler #(
  parameter int unsigned TILE_SHIFT    = 6,
  parameter int unsigned TILES_X       = 10,
  parameter int unsigned TILES_Y       = 7,
  parameter int unsigned KP_THRESHOLD  = 32,
  parameter int unsigned MATCH_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        en,
  input  logic [7:0]  corner,
  input  logic [12:0] col,
  input  logic [12:0] row,
  output logic        match_valid,
  input  logic        match_ready,
  output logic [12:0] kp_x,
  output logic [12:0] kp_y,
  output logic [7:0]  kp_score,
  input  logic        match_done,
  output logic [3:0]  tile_x,
  output logic [3:0]  tile_y,
  output logic        busy,
  output logic        pass_done,
  output logic        match_err
);

  typedef enum logic [2:0] {StIdle, StScan, StDecide, StOffer, StWaitMatch, StNext} state_e;

  localparam logic [12:0] LowMask = 13'((1 << TILE_SHIFT) - 1);

  state_e      state_q, state_d;
  logic [3:0]  tile_x_q, tile_y_q;
  logic [7:0]  max_q;
  logic [12:0] arg_col_q, arg_row_q;
  logic [12:0] kp_x_q, kp_y_q;
  logic [7:0]  kp_score_q;
  logic        pass_done_q;

  logic [12:0] col_tile, row_tile;
  logic        in_tile, tile_end, better, last_tile, wd_expire;

  assign col_tile  = col >> TILE_SHIFT;
  assign row_tile  = row >> TILE_SHIFT;
  assign in_tile   = en && (col_tile == {9'b0, tile_x_q}) && (row_tile == {9'b0, tile_y_q});
  assign tile_end  = in_tile && ((col & LowMask) == LowMask) && ((row & LowMask) == LowMask);
  assign better    = in_tile && (corner > max_q);
  assign last_tile = (tile_x_q == 4'(TILES_X - 1)) && (tile_y_q == 4'(TILES_Y - 1));

`ifdef KTS_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        match_err_q;

  assign wd_expire = (wd_q == MATCH_TIMEOUT - 1);

  // Counts cycles spent in WAIT_MATCH; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q        <= '0;
      match_err_q <= 1'b0;
    end else begin
      wd_q        <= (state_q == StWaitMatch) ? wd_q + 32'd1 : '0;
      match_err_q <= (state_q == StWaitMatch) && !match_done && wd_expire;
    end
  end

  assign match_err = match_err_q;
`else
  // Parameter only matters with the watchdog built in.
  logic unused_timeout;
  assign unused_timeout = ^MATCH_TIMEOUT;
  assign wd_expire      = 1'b0;
  assign match_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start) state_d = StScan;
      StScan:      if (tile_end) state_d = StDecide;
      StDecide:    state_d = (32'(max_q) > KP_THRESHOLD) ? StOffer : StNext;
      StOffer:     if (match_ready) state_d = StWaitMatch;
      StWaitMatch: if (match_done || wd_expire) state_d = StNext;
      StNext:      state_d = last_tile ? StIdle : StScan;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    match_valid = 1'b0;
    busy        = 1'b0;
    if (state_q == StOffer) match_valid = 1'b1;
    if (state_q != StIdle)  busy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      max_q       <= '0;
      arg_col_q   <= '0;
      arg_row_q   <= '0;
      kp_x_q      <= '0;
      kp_y_q      <= '0;
      kp_score_q  <= '0;
      pass_done_q <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            tile_x_q <= '0;
            tile_y_q <= '0;
            max_q    <= '0;
          end
        end
        StScan: begin
          // Strict compare keeps the earliest pixel on ties.
          if (better) begin
            max_q     <= corner;
            arg_col_q <= col;
            arg_row_q <= row;
          end
        end
        StDecide: begin
          if (state_d == StOffer) begin
            kp_x_q     <= arg_col_q;
            kp_y_q     <= arg_row_q;
            kp_score_q <= max_q;
          end
        end
        StNext: begin
          max_q <= '0;
          if (last_tile) begin
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            pass_done_q <= 1'b1;
          end else if (tile_y_q == 4'(TILES_Y - 1)) begin
            tile_y_q <= '0;
            tile_x_q <= tile_x_q + 4'd1;
          end else begin
            tile_y_q <= tile_y_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tile_x    = tile_x_q;
  assign tile_y    = tile_y_q;
  assign kp_x      = kp_x_q;
  assign kp_y      = kp_y_q;
  assign kp_score  = kp_score_q;
  assign pass_done = pass_done_q;

endmodule

// File: tb/tb_keypoint_tile_scheduler.sv
// Directed bench for keypoint_tile_scheduler on a 2x2 tile grid; covers the watchdog path
// when KTS_TIMEOUT_EN is defined.
module tb_keypoint_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, en, match_ready, match_done;
  logic [7:0]  corner;
  logic [12:0] col, row;
  logic        match_valid, busy, pass_done, match_err;
  logic [12:0] kp_x, kp_y;
  logic [7:0]  kp_score;
  logic [3:0]  tile_x, tile_y;

  int n_checks = 0;
  int n_fail   = 0;

  keypoint_tile_scheduler #(
    .TILE_SHIFT   (6),
    .TILES_X      (2),
    .TILES_Y      (2),
    .KP_THRESHOLD (32),
    .MATCH_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .en         (en),
    .corner     (corner),
    .col        (col),
    .row        (row),
    .match_valid(match_valid),
    .match_ready(match_ready),
    .kp_x       (kp_x),
    .kp_y       (kp_y),
    .kp_score   (kp_score),
    .match_done (match_done),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .busy       (busy),
    .pass_done  (pass_done),
    .match_err  (match_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_kp(input string tag, input int x, input int y, input int s);
    chk({tag, "_kp_x"}, 32'(kp_x), x);
    chk({tag, "_kp_y"}, 32'(kp_y), y);
    chk({tag, "_kp_score"}, 32'(kp_score), s);
  endtask

  task automatic chk_tile(input string tag, input int x, input int y);
    chk({tag, "_tile_x"}, 32'(tile_x), x);
    chk({tag, "_tile_y"}, 32'(tile_y), y);
  endtask

  task automatic pix(input logic e, input int c, input int x, input int y);
    en     = e;
    corner = 8'(c);
    col    = 13'(x);
    row    = 13'(y);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; en = 1'b0; match_ready = 1'b0; match_done = 1'b0;
    corner = '0; col = '0; row = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(match_valid), 0);
    chk("rst_pass_done", 32'(pass_done), 0);
    chk("rst_err", 32'(match_err), 0);
    chk_tile("rst", 0, 0);
    chk_kp("rst", 0, 0, 0);
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Tile (0,0): single strong corner, matcher always ready.
    start = 1'b1; tick(); start = 1'b0;
    chk("scan_busy", 32'(busy), 1);
    chk_tile("t00", 0, 0);
    pix(1, 100, 10, 20); tick();
    pix(1, 150, 70, 20); tick();
    pix(1, 0, 63, 63);   tick();
    pix(0, 0, 0, 0);
    chk("t00_decide_valid", 32'(match_valid), 0);
    match_ready = 1'b1;
    tick();
    chk("t00_offer_valid", 32'(match_valid), 1);
    chk_kp("t00", 10, 20, 100);
    tick();
    chk("t00_wait_valid", 32'(match_valid), 0);
    chk("t00_wait_busy", 32'(busy), 1);
    match_done = 1'b1; tick(); match_done = 1'b0;
    chk_tile("t00_next", 0, 0);
    tick();
    chk_tile("t01", 0, 1);

    // Tile (0,1): best score equals threshold, no offer.
    pix(1, 32, 3, 70);   tick();
    pix(1, 0, 63, 127);  tick();
    pix(0, 0, 0, 0);
    chk("t01_decide_valid", 32'(match_valid), 0);
    tick();
    chk("t01_next_valid", 32'(match_valid), 0);
    chk("t01_next_busy", 32'(busy), 1);
    tick();
    chk("t01_scan_valid", 32'(match_valid), 0);
    chk_tile("t10", 1, 0);
    chk_kp("t01_hold", 10, 20, 100);

    // Tile (1,0): tie goes to the first pixel; foreign and disabled pixels ignored.
    pix(1, 200, 69, 5);   tick();
    pix(1, 200, 104, 40); tick();
    pix(1, 250, 5, 5);    tick();
    pix(0, 255, 70, 6);   tick();
    pix(1, 0, 127, 63);   tick();
    pix(0, 0, 0, 0);
    match_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t10_stall_valid", 32'(match_valid), 1);
      chk_kp("t10_stall", 69, 5, 200);
      match_done = (i == 3);
      tick();
    end
    match_done  = 1'b0;
    match_ready = 1'b1;
    chk("t10_c11_valid", 32'(match_valid), 1);
    tick();
    chk("t10_wait_valid", 32'(match_valid), 0);
`ifdef KTS_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t10_wd_err", 32'(match_err), 0);
      chk("t10_wd_busy", 32'(busy), 1);
    end
    tick();
    chk("t10_wd_err_pulse", 32'(match_err), 1);
    tick();
    chk("t10_wd_err_low", 32'(match_err), 0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t10_wait_err", 32'(match_err), 0);
    end
    chk("t10_wait_busy", 32'(busy), 1);
    chk_tile("t10_wait", 1, 0);
    match_done = 1'b1; tick(); match_done = 1'b0;
    tick();
`endif
    chk_tile("t11", 1, 1);

    // Tile (1,1): start mid-pass ignored, then pass completes.
    start = 1'b1; tick(); start = 1'b0;
    chk("t11_busy", 32'(busy), 1);
    chk_tile("t11_after_start", 1, 1);
    pix(1, 0, 127, 127); tick();
    pix(0, 0, 0, 0);
    tick();
    chk("t11_next_pass_done", 32'(pass_done), 0);
    tick();
    chk("end_pass_done", 32'(pass_done), 1);
    chk("end_busy", 32'(busy), 0);
    chk_tile("end", 0, 0);
    chk_kp("end_hold", 69, 5, 200);
    tick();
    chk("end_pass_done_low", 32'(pass_done), 0);

    // Reset while offering aborts the handshake.
    start = 1'b1; tick(); start = 1'b0;
    match_ready = 1'b0;
    pix(1, 100, 1, 1);  tick();
    pix(1, 0, 63, 63);  tick();
    pix(0, 0, 0, 0);
    tick();
    chk("abort_offer_valid", 32'(match_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", 32'(match_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk_kp("abort", 0, 0, 0);
    chk_tile("abort", 0, 0);
    match_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_after_valid", 32'(match_valid), 0);
    chk("abort_after_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
